// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised Moore sequence detector with runtime pattern
// Optional saturating match counter and cnt_clr/match_cnt ports built when SEQ_DETECT_CNT_EN is defined.
module seq_detect_param #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] RESET_PAT = 4'b1011,
  parameter int                   CNT_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           x_vld,
  input  logic                           x,
  input  logic                           overlap_en,
  input  logic                           pat_load,
  input  logic [PATTERN_W-1:0]           pat_in,
`ifdef SEQ_DETECT_CNT_EN
  input  logic                           cnt_clr,
  output logic [CNT_W-1:0]               match_cnt,
`endif
  output logic                           z,
  output logic [$clog2(PATTERN_W+1)-1:0] state_o
);

  localparam int              SW     = $clog2(PATTERN_W + 1);
  localparam logic [SW-1:0]   S_FULL = SW'(PATTERN_W);

  if (PATTERN_W < 2 || PATTERN_W > 16 || CNT_W < 1) begin : g_param_check
    $error("seq_detect_param: parameter out of range");
  end

  logic [SW-1:0]        state_q, state_d, state_nxt;
  logic [PATTERN_W-1:0] pat_q, pat_d, prefix;
  logic [PATTERN_W:0]   cand, mask_k, pat_k;
  logic                 z_q, z_d;
  int                   s_eff;

  // Candidate = matched prefix followed by x; keep the longest suffix that is a pattern prefix.
  always_comb begin
    s_eff     = (state_q == S_FULL && !overlap_en) ? 0 : int'(state_q);
    prefix    = pat_q >> (PATTERN_W - s_eff);
    cand      = {prefix, x};
    state_nxt = '0;
    mask_k    = '0;
    pat_k     = '0;
    for (int k = 1; k <= PATTERN_W; k++) begin
      mask_k = {(PATTERN_W + 1){1'b1}} >> (PATTERN_W + 1 - k);
      pat_k  = {1'b0, pat_q >> (PATTERN_W - k)};
      if (k <= s_eff + 1 && (cand & mask_k) == pat_k) begin
        state_nxt = SW'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    if (pat_load) begin
      pat_d   = pat_in;
      state_d = '0;
    end else if (x_vld) begin
      state_d = state_nxt;
    end
    z_d = (state_d == S_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
      pat_q   <= RESET_PAT;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      z_q     <= z_d;
    end
  end

  assign z       = z_q;
  assign state_o = state_q;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (!pat_load && x_vld && state_nxt == S_FULL && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised Moore sequence detector for a serial bit stream. It matches a runtime-programmable pattern of `PATTERN_W` bits. Overlapping or non-overlapping detection is selectable per bit, and a saturating match counter can be compiled in. It sits on a serial data path behind any source that supplies one bit per qualified cycle, and flags each completed pattern with a registered, state-decoded output.

## Interface
- `PATTERN_W`, 4: pattern length in bits, 2..16.
- `RESET_PAT`, 4'b1011: pattern register value after reset.
- `CNT_W`, 8: width of the match counter.
- `clk` in 1: single clock; all logic updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `x_vld` in 1: qualifies `x`; a bit is accepted only on edges where `x_vld`=1.
- `x` in 1: serial data bit.
- `overlap_en` in 1: 1 selects overlapping detection, 0 selects non-overlapping; sampled with each accepted bit.
- `pat_load` in 1: loads `pat_in` into the pattern register.
- `pat_in` in PATTERN_W: new pattern; bit [PATTERN_W-1] is the first bit expected.
- `cnt_clr` in 1: clears the match counter.
- `z` out 1: match flag, high while state == PATTERN_W.
- `state_o` out $clog2(PATTERN_W+1): current state, exported for debug.
- `match_cnt` out CNT_W: saturating count of matches (present only with the macro; see Configuration).

## Operation
- State S = number of pattern prefix bits currently matched, 0..PATTERN_W. Reset state is 0.
- Next-state rule on an accepted bit:
  - Form the candidate string: the first S pattern bits followed by `x`.
  - Next S = the largest k ≤ PATTERN_W such that the last k bits of the candidate equal pattern bits [PATTERN_W-1 : PATTERN_W-k].
  - If no such k exists, next S = 0.
  - This logic is combinational, a priority search from k=PATTERN_W down to 1. No history register is kept.
- From S=PATTERN_W with `overlap_en`=1: the rule above is applied to the full pattern (failure fallback). This is the overlapping case.
- From S=PATTERN_W with `overlap_en`=0: evaluate as if S=0. This is the non-overlapping case.
- `x_vld`=0: S holds; `z` holds.
- `z` = (S == PATTERN_W). It is a Moore output and depends on state only, never on `x`.
- `pat_load`=1:
  - The pattern register takes `pat_in` and S goes to 0.
  - If `x_vld` is also high that cycle, the bit is discarded.
  - `pat_load` has priority over bit acceptance.
- Match event = an accepted bit that moves S to PATTERN_W. This includes PATTERN_W→PATTERN_W in overlapping mode, e.g. pattern 1111.
- Counter behaviour:
  - `match_cnt` increments by 1 on each match event and saturates at 2^CNT_W-1.
  - `cnt_clr` has priority over an increment in the same cycle; the result is 0.
  - `pat_load` does not clear the counter.

## Timing
- Reset (`rst_n`=0 at an edge) sets:
  - S=0, so `z`=0 and `state_o`=0;
  - `match_cnt`=0;
  - pattern register=RESET_PAT.
- Reset overrides every other input, including a reset asserted mid-match.
- Detection latency: `z` rises in the cycle after the edge that accepts the final pattern bit.
  - It stays high until the next accepted bit or `pat_load` moves S away.
  - In overlapping mode it can remain high across consecutive matches.
- `match_cnt` updates on the same edge that S enters (or re-enters) PATTERN_W.
- `cnt_clr` takes effect on the next edge.
- A new pattern is effective for the first bit accepted after the load edge.

## Configuration
- `SEQ_DETECT_CNT_EN` defined:
  - `cnt_clr` and `match_cnt` ports exist;
  - the counter behaves as specified above.
- Not defined:
  - both ports are absent and no counter logic is built;
  - all detection behaviour is identical.

## Test plan
- **Overlap:** default pattern 1011, `overlap_en`=1, stream 1,0,1,1,0,1,1 (`x_vld`=1 each cycle) -> `z` high after bit 4 and after bit 7; `match_cnt`=2.
- **Non-overlap:** same stream with `overlap_en`=0 -> `z` high only after bit 4; `match_cnt`=1; S=1 at the end.
- **Self-overlap:** load 1111, stream 1,1,1,1,1,1 overlapping -> `z` high continuously from after bit 4; `match_cnt`=3.
  - With `overlap_en`=0 the same stream gives one match and S=2 at the end.
- **Gaps and load:**
  - Stream 1,0,1 with `x_vld` low for 5 cycles, then 1 -> `z` high after the final bit and held while `x_vld`=0.
  - `pat_load`=1 with `x_vld`=1 in S=3 -> S=0, bit dropped, `z`=0.
- **Saturation and clear:** CNT_W=2, 5 matches -> `match_cnt`=3.
  - `cnt_clr` on the same edge as a 6th match -> `match_cnt`=0.
- **Reset:** `rst_n`=0 for one edge while S=PATTERN_W -> `z`=0, `match_cnt`=0, pattern=1011.
  - With `rst_n`=0 held and `x_vld`=1, S stays 0.
